// File: rtl/instruction_fetch.sv
// Fetch stage of the MIPS pipeline: PC register, next-PC selection and the IF/ID register.
// Redirects from decode squash the wrong-path fetch, so each redirect costs exactly one bubble.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] read_address,
   input  logic [31:0] inst,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid,
   output logic [31:0] fetch_count
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        redirect;

   assign read_address = pc;
   assign pc_plus4     = pc + 32'd4;
   assign redirect     = (jr | jump | branch_taken) & ~stall;

   // Jump region bits come from the IF/ID copy of PC+4, i.e. the jump's own delay-slot address.
   always_comb begin
      next_pc = pc_plus4;
      if (stall)
         next_pc = pc;
      else if (jr)
         next_pc = {jr_target[31:2], 2'b00};
      else if (jump)
         next_pc = {ifid_pc_plus4[31:28], jump_index, 2'b00};
      else if (branch_taken)
         next_pc = {branch_target[31:2], 2'b00};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc            <= {RESET_PC[31:2], 2'b00};
         ifid_inst     <= NOP_INST;
         ifid_pc_plus4 <= 32'd0;
         ifid_valid    <= 1'b0;
         fetch_count   <= 32'd0;
      end else if (!stall) begin
         pc <= {next_pc[31:2], 2'b00};
         if (redirect) begin
            ifid_inst     <= NOP_INST;
            ifid_pc_plus4 <= 32'd0;
            ifid_valid    <= 1'b0;
         end else begin
            ifid_inst     <= inst;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
            fetch_count   <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expected pipeline state is queued per step
// and compared after each edge against a small instruction-memory table.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic        jr;
   logic [31:0] jr_target;
   logic [31:0] read_address;
   logic [31:0] inst;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;
   logic [31:0] fetch_count;

   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic [31:0] iinst;
      logic [31:0] pc4;
      logic        valid;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;

   instruction_fetch dut (
      .clk(clk), .rst(rst), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_index(jump_index),
      .jr(jr), .jr_target(jr_target),
      .read_address(read_address), .inst(inst),
      .ifid_inst(ifid_inst), .ifid_pc_plus4(ifid_pc_plus4),
      .ifid_valid(ifid_valid), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0:   return 32'h2008_0001;
         32'h4:   return 32'h2009_0002;
         32'h8:   return 32'h0109_5020;
         32'hC:   return 32'h0000_0000;
         default: return 32'hC000_0000 | a;
      endcase
   endfunction

   always_comb inst = mem_word(read_address);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] ii,
                               input logic [31:0] pc4, input logic v, input logic [31:0] cnt);
      exp_t e;
      e.tag = tag; e.pc = pc; e.iinst = ii; e.pc4 = pc4; e.valid = v; e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic check_front();
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".pc"},    read_address,      e.pc);
      chk({e.tag, ".inst"},  ifid_inst,         e.iinst);
      chk({e.tag, ".pc4"},   ifid_pc_plus4,     e.pc4);
      chk({e.tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
      chk({e.tag, ".cnt"},   fetch_count,       e.cnt);
   endtask

   task automatic edge_check();
      @(posedge clk);
      #1;
      check_front();
   endtask

   task automatic idle_inputs();
      stall = 0; branch_taken = 0; branch_target = 0;
      jump = 0; jump_index = 0; jr = 0; jr_target = 0;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 0;
      idle_inputs();
      #2;
      expect_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      check_front();
      #10 rst = 1;

      // Free-running fetch from RESET_PC
      expect_state("seq1", 32'h4,  32'h2008_0001, 32'h4,  1'b1, 32'd1); edge_check();
      expect_state("seq2", 32'h8,  32'h2009_0002, 32'h8,  1'b1, 32'd2); edge_check();
      expect_state("seq3", 32'hC,  32'h0109_5020, 32'hC,  1'b1, 32'd3); edge_check();
      expect_state("seq4", 32'h10, 32'h0000_0000, 32'h10, 1'b1, 32'd4); edge_check();

      // jr back to 0x8 with unaligned target
      jr = 1; jr_target = 32'h0000_000B;
      expect_state("jr8", 32'h8, 32'h0, 32'h0, 1'b0, 32'd4); edge_check();
      idle_inputs();

      // Taken branch while pc = 0x8
      branch_taken = 1; branch_target = 32'h0000_0041;
      expect_state("br_bubble", 32'h40, 32'h0, 32'h0, 1'b0, 32'd4); edge_check();
      idle_inputs();
      expect_state("br_target", 32'h44, 32'hC000_0040, 32'h44, 1'b1, 32'd5); edge_check();

      // Set up ifid_pc_plus4 = 0x3000_0010
      jr = 1; jr_target = 32'h3000_000C;
      expect_state("jr_3000", 32'h3000_000C, 32'h0, 32'h0, 1'b0, 32'd5); edge_check();
      idle_inputs();
      expect_state("fetch_3000", 32'h3000_0010, 32'hF000_000C, 32'h3000_0010, 1'b1, 32'd6); edge_check();

      // Jump beats branch
      jump = 1; jump_index = 26'h0000100; branch_taken = 1; branch_target = 32'h0000_0500;
      expect_state("jump_vs_br", 32'h3000_0400, 32'h0, 32'h0, 1'b0, 32'd6); edge_check();
      idle_inputs();

      // Jump during a bubble: region bits from ifid_pc_plus4 (0), not from pc
      jump = 1; jump_index = 26'h3FF_FFFF;
      expect_state("jump_region", 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd6); edge_check();
      idle_inputs();
      expect_state("fetch_0fff", 32'h1000_0000, 32'hCFFF_FFFC, 32'h1000_0000, 1'b1, 32'd7); edge_check();

      // Stall with jr pending
      stall = 1; jr = 1; jr_target = 32'h0000_0100;
      for (int i = 0; i < 3; i++) begin
         expect_state("stall", 32'h1000_0000, 32'hCFFF_FFFC, 32'h1000_0000, 1'b1, 32'd7);
         edge_check();
      end
      stall = 0;
      expect_state("jr_after_stall", 32'h100, 32'h0, 32'h0, 1'b0, 32'd7); edge_check();
      idle_inputs();
      expect_state("fetch_100", 32'h104, 32'hC000_0100, 32'h104, 1'b1, 32'd8); edge_check();

      // PC wrap
      jr = 1; jr_target = 32'hFFFF_FFFF;
      expect_state("jr_top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd8); edge_check();
      idle_inputs();
      expect_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd9); edge_check();
      expect_state("after_wrap", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'd10); edge_check();

      // All three redirects: jr wins
      jr = 1; jr_target = 32'h0000_0200; jump = 1; jump_index = 26'h0000_055;
      branch_taken = 1; branch_target = 32'h0000_0300;
      expect_state("jr_prio", 32'h200, 32'h0, 32'h0, 1'b0, 32'd10); edge_check();
      idle_inputs();
      branch_taken = 1; branch_target = 32'h0000_0027;
      expect_state("br_24", 32'h24, 32'h0, 32'h0, 1'b0, 32'd10); edge_check();
      idle_inputs();
      stall = 1;
      expect_state("stall_24", 32'h24, 32'h0, 32'h0, 1'b0, 32'd10); edge_check();

      // Asynchronous reset between edges while stalled at 0x24
      #1 rst = 0;
      #1;
      expect_state("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
      check_front();
      @(negedge clk);
      expect_state("rst_held", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0); edge_check();
      @(negedge clk);
      rst = 1; stall = 0;
      expect_state("post_rst", 32'h4, 32'h2008_0001, 32'h4, 1'b1, 32'd1); edge_check();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

PC register, next-PC selection and IF/ID pipeline register for the MIPS CPU. Sits directly upstream of `Instruction_Memory`: drives its `read_address`, captures the returned `inst` together with PC+4 into the IF/ID register, and hands both to the decode stage. Decode sends stall and redirect requests back (branch, `j`/`jal`, `jr`); this block resolves them cycle-accurately.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0000, instruction word injected into IF/ID on flush/reset (`sll $0,$0,0`).

Ports:
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hold PC and IF/ID (load-use hazard in ID).
- `branch_taken`  input  1  conditional branch in ID resolved taken.
- `branch_target`  input  32  branch destination computed in ID.
- `jump`  input  1  `j`/`jal` in ID.
- `jump_index`  input  26  instr_index field of the jump in ID.
- `jr`  input  1  `jr`/`jalr` in ID.
- `jr_target`  input  32  register value for `jr`.
- `read_address`  output  32  to `Instruction_Memory.read_address`; equals current PC.
- `inst`  input  32  from `Instruction_Memory.inst`; combinational, valid in the same cycle as `read_address`.
- `ifid_inst`  output  32  registered instruction for ID.
- `ifid_pc_plus4`  output  32  registered PC+4 of `ifid_inst`.
- `ifid_valid`  output  1  1 = `ifid_inst` is a real fetched instruction, 0 = bubble.
- `fetch_count`  output  32  number of instructions loaded into IF/ID with valid=1.

## Operation
- PC register `pc`; `read_address = pc` (combinational).
- Next-PC selection, first match wins:
  1. `stall`=1: pc holds; all redirect inputs ignored this cycle.
  2. `jr`: `{jr_target[31:2], 2'b00}`.
  3. `jump`: `{ifid_pc_plus4[31:28], jump_index, 2'b00}`. Upper bits come from the IF/ID-held PC+4, not the current PC.
  4. `branch_taken`: `{branch_target[31:2], 2'b00}`.
  5. Otherwise: `pc + 4`, 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Low two bits of every redirect target are forced to 00; `pc[1:0]` is always 00.
- Redirect = (`jr`|`jump`|`branch_taken`) & !`stall`.
- IF/ID update, first match wins:
  1. `stall`: hold all three fields.
  2. Redirect: load bubble (`NOP_INST`, pc_plus4 = 0, valid = 0). No delay slot; the wrong-path instruction is squashed.
  3. Otherwise: load `inst`, `pc+4`, valid = 1.
- `fetch_count` increments by 1 (modulo 2^32) on each edge in which IF/ID loads with valid=1. It holds on stall and on flush.
- Reset (`rst`=0, asynchronous, immediate): pc = `RESET_PC`, `ifid_inst` = `NOP_INST`, `ifid_pc_plus4` = 0, `ifid_valid` = 0, `fetch_count` = 0. Reset wins over every other input. Asserting it mid-stall or mid-redirect discards the pending operation.

## Timing
- Fetch latency: the instruction at PC A appears on `ifid_inst` one edge after `read_address` = A, provided there is no stall or redirect.
- Redirect seen in cycle N (decode of `ifid_inst`):
  - Edge ending N: pc = target and IF/ID = bubble.
  - Cycle N+1: `read_address` = target.
  - Edge ending N+1: target instruction enters IF/ID.
  - Penalty: exactly 1 bubble.
- Stall in cycle N: pc, IF/ID and `fetch_count` are unchanged after the edge. `read_address` is stable for the whole stall; `inst` is re-sampled when the stall drops.
- Multiple redirect inputs in one cycle: only the highest-priority one takes effect. Still one bubble.
- Back-to-back redirects: the second occurs in cycle N+1 while ID holds a bubble. Decode must gate redirects with `ifid_valid`. This block does not gate them; a redirect input with `ifid_valid`=0 is still honoured.
- First rising edge after `rst` deasserts: fetches at `RESET_PC`. No extra warm-up cycle.

## Test plan
- Reset, then 4 free-running cycles with memory words 0x20080001, 0x20090002, 0x01095020, 0x00000000 at 0x0/0x4/0x8/0xC → `read_address` goes 0,4,8,C,10. `ifid_inst` follows one cycle later with pc_plus4 4,8,C,10 and valid=1. `fetch_count` = 4.
- `branch_taken`=1, `branch_target`=0x0000_0041 while pc = 0x8 → next pc = 0x40, IF/ID bubble (valid=0, inst=0). At the next edge IF/ID = mem[0x40], pc_plus4 = 0x44. `fetch_count` does not increment on the bubble edge.
- `ifid_pc_plus4`=0x3000_0010, `jump`=1, `jump_index`=26'h0000100, with `branch_taken`=1 in the same cycle → pc = 0x3000_0400 (jump beats branch).
- `stall`=1 for 3 cycles with `jr`=1, `jr_target`=0x100 held throughout → pc, IF/ID and `fetch_count` unchanged for all 3 edges. With stall dropped and `jr` still high → pc = 0x100, one bubble.
- pc = 0xFFFF_FFFC, no redirect → pc wraps to 0x0, `ifid_pc_plus4` = 0x0.
- `rst` pulsed low between edges while pc = 0x24 and `stall`=1 → outputs reach their reset values immediately, without waiting for `clk`. After release, the first fetch is at `RESET_PC`.
